mips_muldiv: RTL and testbench

MIPS_MULDIV -- requirements
Module: mips_muldiv

---
 rtl/mips_muldiv_pkg.sv | 19 +
 rtl/mips_muldiv.sv | 133 +++++++++++++
 tb/tb_mips_muldiv.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply-divide unit.
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIXUP = 2'b10
    } state_t;

    localparam int ITERATIONS = 32;

endpackage

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit with MIPS HI/LO registers.
// Multiply and divide share one 64-bit working register and one counter.
module mips_muldiv
    import mips_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

    state_t      state;
    state_t      next_state;
    op_t         op_reg;
    logic [5:0]  count;
    logic [63:0] work;
    logic [31:0] operand;
    logic        neg_result;
    logic        neg_rem;

    logic        op_signed;
    logic        op_div;
    logic        div_zero;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] add_sum;
    logic [32:0] trial;
    logic [63:0] step_next;

    // Operand preparation; a divide by zero keeps the raw dividend so it lands in HI untouched.
    always_comb begin
        op_signed = op[0];
        op_div    = op[1];
        div_zero  = op_div && (src_b == 32'd0);
        sign_a    = op_signed && src_a[31];
        sign_b    = op_signed && src_b[31];
        mag_a     = (sign_a && !div_zero) ? -src_a : src_a;
        mag_b     = sign_b ? -src_b : src_b;
    end

    // One shift-add or restoring-subtract step on the shared working register.
    always_comb begin
        add_sum = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
        trial   = {work[63:32], work[31]} - {1'b0, operand};
        if (op_reg inside {OP_DIVU, OP_DIV}) begin
            if (trial[32])
                step_next = {work[62:0], 1'b0};
            else
                step_next = {trial[31:0], work[30:0], 1'b1};
        end else begin
            step_next = {add_sum, work[31:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (count == LAST_ITER) next_state = S_FIXUP;
            S_FIXUP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg     <= OP_MULTU;
            count      <= 6'd0;
            work       <= 64'd0;
            operand    <= 32'd0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start in the same cycle as mthi/mtlo takes priority and drops the move.
                    if (start) begin
                        op_reg     <= op_t'(op);
                        count      <= 6'd0;
                        work       <= {32'd0, mag_a};
                        operand    <= mag_b;
                        neg_result <= !div_zero && (sign_a ^ sign_b);
                        neg_rem    <= !div_zero && sign_a;
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                S_RUN: begin
                    work  <= step_next;
                    count <= count + 6'd1;
                end
                S_FIXUP: begin
                    done <= 1'b1;
                    if (op_reg inside {OP_DIVU, OP_DIV}) begin
                        lo <= neg_result ? -work[31:0]  : work[31:0];
                        hi <= neg_rem    ? -work[63:32] : work[63:32];
                    end else begin
                        {hi, lo} <= neg_result ? -work : work;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed vectors, corner sequences and a randomized arithmetic model.
module tb_mips_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] result;
    } vec_t;

    vec_t vecs[$];

    mips_muldiv dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (busy && done) begin
                fails++;
                $display("[TB] FAIL busy_done_overlap: busy=%0b done=%0b required not both high", busy, done);
            end
        end
    end

    // Reference arithmetic: {hi, lo} from plain integer operations.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (o)
            2'b00: res = {32'd0, a} * {32'd0, b};
            2'b01: res = 64'(sa * sb);
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    res = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issues one operation and checks the full 33-cycle timeline; with_mt also raises mtlo alongside start.
    task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] result, input logic with_mt);
        logic early;
        @(negedge clk);
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (with_mt) begin
            mtlo = 1'b1;
            mt_data = 32'h0000_5555;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        mtlo = 1'b0;
        checkOutput({name, " busy_after_start"}, 64'(busy), 64'd1);
        if (with_mt) checkOutput({name, " mtlo_dropped"}, 64'(lo), 64'(exp_lo));
        early = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if (done || !busy) early = 1'b1;
        end
        checkOutput({name, " early_done_or_idle"}, 64'(early), 64'd0);
        checkOutput({name, " hold_prev"}, {hi, lo}, {exp_hi, exp_lo});
        @(posedge clk);
        #1;
        checkOutput({name, " done"}, 64'(done), 64'd1);
        checkOutput({name, " busy_clear"}, 64'(busy), 64'd0);
        checkOutput({name, " result"}, {hi, lo}, result);
        exp_hi = result[63:32];
        exp_lo = result[31:0];
        @(posedge clk);
        #1;
        checkOutput({name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          extra_done;

        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        src_a = 32'd0;
        src_b = 32'd0;
        mthi = 1'b0;
        mtlo = 1'b0;
        mt_data = 32'd0;

        #12;
        checkOutput("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        vecs.push_back('{"multu_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{"mult_m7x3",   2'b01, 32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB});
        vecs.push_back('{"div_m7d2",    2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{"divu_by0",    2'b10, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF});
        vecs.push_back('{"div_ovf",     2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
        vecs.push_back('{"divu_10d3",   2'b10, 32'd10,        32'd3,         64'h0000_0001_0000_0003});
        vecs.push_back('{"div_7dm2",    2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
        vecs.push_back('{"mult_min2",   2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{"div_m5by0",   2'b11, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF});
        vecs.push_back('{"multu_zero",  2'b00, 32'd0,         32'h1234_5678, 64'd0});
        vecs.push_back('{"div_m9dm4",   2'b11, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 64'hFFFF_FFFF_0000_0002});

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].result, 1'b0);

        // Simultaneous mthi and mtlo while idle.
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        mt_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        checkOutput("mthi_mtlo_both", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
        exp_hi = 32'hCAFE_F00D;
        exp_lo = 32'hCAFE_F00D;

        // Start and mtlo together: the operation wins.
        applyStimulus("start_vs_mtlo", 2'b00, 32'd6, 32'd7, 64'd42, 1'b1);

        // Collision: start and mthi while busy are ignored.
        @(negedge clk);
        op = 2'b10;
        src_a = 32'd10;
        src_b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        extra_done = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1;
                op = 2'b00;
                src_a = 32'd2;
                src_b = 32'd2;
                mthi = 1'b1;
                mt_data = 32'h0000_DEAD;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            mthi = 1'b0;
            if (done) extra_done++;
        end
        @(posedge clk);
        #1;
        checkOutput("collision_done", 64'(done), 64'd1);
        checkOutput("collision_result", {hi, lo}, 64'h0000_0001_0000_0003);
        exp_hi = 32'd1;
        exp_lo = 32'd3;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        checkOutput("collision_single_done", 64'(extra_done), 64'd0);

        // Reset mid-operation aborts with no done and clears HI/LO.
        @(negedge clk);
        op = 2'b00;
        src_a = 32'd5;
        src_b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midop_reset", {30'd0, busy, done, hi, lo}, 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        checkOutput("midop_no_done", 64'(extra_done), 64'd0);
        checkOutput("midop_hilo_zero", {hi, lo}, 64'd0);
        @(negedge clk);
        mtlo = 1'b1;
        mt_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        checkOutput("mtlo_after_reset", {hi, lo}, 64'h0000_0000_0000_1234);
        exp_lo = 32'h0000_1234;

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: r_a = 32'h8000_0000;
                1: r_a = 32'($urandom_range(0, 255));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_b = 32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            applyStimulus($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, model(r_op, r_a, r_b), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
